// File: rtl/fifo_sync_pkg.sv
// Shared defaults and helpers for the fifo_sync block.
package fifo_sync_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Storage array for fifo_sync: synchronous write port and a registered read port.
module fifo_sync_mem
  import fifo_sync_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [clog2(FIFO_DEPTH)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  input  logic [clog2(FIFO_DEPTH)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data
);

  logic [DATA_WIDTH-1:0] storage [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // The array itself is never reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      storage[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = storage[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with one-cycle registered read data.
// Define FIFO_SYNC_STATUS_EN to add count/overflow/underflow status outputs.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cs,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         empty,
  output logic                         full
`ifdef FIFO_SYNC_STATUS_EN
  ,
  output logic [clog2(FIFO_DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic          wr_accept;
  logic          rd_accept;

  // The extra pointer MSB distinguishes a full buffer from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    wr_accept = cs && wr_en && !full;
    rd_accept = cs && rd_en && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_sync_mem #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (data_out)
  );

`ifdef FIFO_SYNC_STATUS_EN
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (cs && wr_en && full);
    underflow_d = underflow_q || (cs && rd_en && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = wr_ptr_q - rd_ptr_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (default depth 8, width 32).
module tb_fifo_sync;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        empty;
  logic        full;
`ifdef FIFO_SYNC_STATUS_EN
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
`endif

  int errors = 0;
  int checks = 0;

  fifo_sync #(
    .FIFO_DEPTH (8),
    .DATA_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
`ifdef FIFO_SYNC_STATUS_EN
    ,
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs and returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic c, input logic w, input logic r, input logic [31:0] d);
    cs      = c;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_data_out", data_out, 32'd0);
    rst_n = 1'b1;

    // Three writes then three reads in order
    applyStimulus(1, 1, 0, 32'd1);
    checkOutput("w1_not_empty", 32'(empty), 32'd0);
    applyStimulus(1, 1, 0, 32'd10);
    applyStimulus(1, 1, 0, 32'd100);
    applyStimulus(1, 0, 1, 32'd0);
    checkOutput("seq_rd0", data_out, 32'd1);
    applyStimulus(1, 0, 1, 32'd0);
    checkOutput("seq_rd1", data_out, 32'd10);
    applyStimulus(1, 0, 1, 32'd0);
    checkOutput("seq_rd2", data_out, 32'd100);
    checkOutput("seq_empty", 32'(empty), 32'd1);

    // Walking ones, one write then one read each
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 0, 32'(1) << i);
      checkOutput("walk_full_after_wr", 32'(full), 32'd0);
      applyStimulus(1, 0, 1, 32'd0);
      checkOutput("walk_rd", data_out, 32'(1) << i);
      checkOutput("walk_empty", 32'(empty), 32'd1);
    end

    // Fill to full, overfill is dropped
    for (int i = 0; i < 8; i++) begin
      checkOutput("fill_full_early", 32'(full), 32'd0);
      applyStimulus(1, 1, 0, 32'(1) << i);
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    applyStimulus(1, 1, 0, 32'd256);
    checkOutput("fill_full_held", 32'(full), 32'd1);
`ifdef FIFO_SYNC_STATUS_EN
    checkOutput("fill_count", 32'(count), 32'd8);
    checkOutput("fill_overflow", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 1, 32'd0);
      checkOutput("drain_rd", data_out, 32'(1) << i);
      checkOutput("drain_full", 32'(full), 32'd0);
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);

    // Read while empty holds data_out and leaves pointers alone
    applyStimulus(1, 0, 1, 32'd0);
    checkOutput("under_hold", data_out, 32'd128);
    checkOutput("under_empty", 32'(empty), 32'd1);
`ifdef FIFO_SYNC_STATUS_EN
    checkOutput("under_flag", 32'(underflow), 32'd1);
`endif
    applyStimulus(1, 1, 0, 32'd7);
    applyStimulus(1, 0, 1, 32'd0);
    checkOutput("under_after_rd", data_out, 32'd7);
    checkOutput("under_after_empty", 32'(empty), 32'd1);

    // Simultaneous read/write with 4 entries held, across pointer wrap
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 32'h11 + 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 1, 32'h15 + 32'(i));
      checkOutput("rw_data", data_out, 32'h11 + 32'(i));
      checkOutput("rw_empty", 32'(empty), 32'd0);
      checkOutput("rw_full", 32'(full), 32'd0);
`ifdef FIFO_SYNC_STATUS_EN
      checkOutput("rw_count", 32'(count), 32'd4);
`endif
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 32'hdead);
      checkOutput("cs0_hold", data_out, 32'h16);
      checkOutput("cs0_empty", 32'(empty), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 1, 32'd0);
      checkOutput("rw_drain", data_out, 32'h17 + 32'(i));
    end
    checkOutput("rw_drain_empty", 32'(empty), 32'd1);

    // Write to full FIFO with concurrent read: read accepted, write dropped
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 0, 32'h40 + 32'(i));
    end
    applyStimulus(1, 1, 1, 32'h99);
    checkOutput("fullrw_data", data_out, 32'h40);
    checkOutput("fullrw_full", 32'(full), 32'd0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1, 0, 1, 32'd0);
      checkOutput("fullrw_drain", data_out, 32'h40 + 32'(i));
    end
    checkOutput("fullrw_empty", 32'(empty), 32'd1);

    // Asynchronous reset in the middle of a burst
    applyStimulus(1, 1, 0, 32'h31);
    applyStimulus(1, 1, 0, 32'h32);
    applyStimulus(1, 1, 1, 32'h33);
    checkOutput("pre_rst_data", data_out, 32'h31);
    cs = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h34;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_empty", 32'(empty), 32'd1);
    checkOutput("async_rst_full", 32'(full), 32'd0);
    checkOutput("async_rst_data", data_out, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_held_empty", 32'(empty), 32'd1);
    checkOutput("rst_held_data", data_out, 32'd0);
`ifdef FIFO_SYNC_STATUS_EN
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
`endif
    rst_n = 1'b1;
    applyStimulus(1, 1, 0, 32'd5);
    checkOutput("post_rst_wr_empty", 32'(empty), 32'd0);
    applyStimulus(1, 0, 1, 32'd0);
    checkOutput("post_rst_rd", data_out, 32'd5);
    checkOutput("post_rst_empty", 32'(empty), 32'd1);

    applyStimulus(0, 0, 0, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: number of entries; power of two, at least 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bits per entry.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cs, input, 1: chip select; gates wr_en and rd_en.
REQ-006 SHALL have port wr_en, input, 1: write request.
REQ-007 SHALL have port rd_en, input, 1: read request.
REQ-008 SHALL have port data_in, input, DATA_WIDTH: write data.
REQ-009 SHALL have port data_out, output, DATA_WIDTH: registered read data.
REQ-010 SHALL have port empty, output, 1: FIFO holds zero entries.
REQ-011 SHALL have port full, output, 1: FIFO holds FIFO_DEPTH entries.

Function
REQ-012 SHALL accept a write on a rising edge iff cs=1, wr_en=1 and full=0; data_in is stored at the write pointer and the write pointer advances by 1.
REQ-013 SHALL accept a read on a rising edge iff cs=1, rd_en=1 and empty=0; the entry at the read pointer loads into data_out on that edge and the read pointer advances by 1.
REQ-014 SHALL give read data one cycle of latency: data_out is valid after the accepting edge and holds until the next accepted read.
REQ-015 SHALL silently drop a write while full=1 (no pointer or storage change) and ignore a read while empty=1 (data_out holds).
REQ-016 SHALL ignore wr_en and rd_en entirely while cs=0.
REQ-017 SHALL permit a read and a write on the same edge when each is individually accepted; occupancy is unchanged.
REQ-018 SHALL evaluate full and empty from the pre-edge state: a write to a full FIFO is dropped even when a read is accepted on the same edge.
REQ-019 SHALL use pointers of log2(FIFO_DEPTH)+1 bits that wrap modulo 2*FIFO_DEPTH; empty = pointers equal; full = MSBs differ and lower bits equal.
REQ-020 SHALL drive full and empty as registered or pointer-derived values, glitch-free and valid in the cycle after each accepted operation.
REQ-021 SHALL return data in strict write order across pointer wrap-around.

Reset
REQ-022 SHALL, while rst_n=0, force read and write pointers to 0, data_out to 0, empty to 1, and full to 0, independent of clk.
REQ-023 SHALL discard all contents on reset mid-operation; storage array contents are not reset and are unobservable until rewritten.
REQ-024 SHALL ignore requests on any edge where rst_n=0; the first edge after deassertion operates normally.

Configuration
REQ-025 SHALL, when macro FIFO_SYNC_STATUS_EN is defined, add outputs count (log2(FIFO_DEPTH)+1 bits, current occupancy), overflow (sticky, set by a dropped write), and underflow (sticky, set by an ignored read); all three clear only on reset.
REQ-026 SHALL, without FIFO_SYNC_STATUS_EN, omit these ports and logic; core behaviour is identical in both builds.

Structure
REQ-027 SHALL take default parameter constants and a ceiling-log2 function from shared package fifo_sync_pkg.
REQ-028 SHALL place storage in sub-module fifo_sync_mem: a DATA_WIDTH x FIFO_DEPTH array with synchronous write and a registered read port. Pointer, flag and status logic stays in fifo_sync.

Verification
REQ-029 After reset, write 1, 10, 100, then read three times -> data_out 1, 10, 100 in order; empty=1 after the third read.
REQ-030 For i=0..7, write 2**i and then read once -> each read returns 2**i; empty=1 after every read; full never asserts.
REQ-031 Write 2**i for i=0..8 -> full=1 after the 8th write; the 9th value (256) is dropped; the 8 subsequent reads return 1, 2, 4, ... 128, then empty=1.
REQ-032 Read while empty -> data_out holds its prior value and pointers are unchanged; with FIFO_SYNC_STATUS_EN, underflow=1.
REQ-033 Hold 4 entries, drive cs=1, wr_en=1, rd_en=1 for 6 cycles -> count stays 4 and outputs remain in order across the wrap; with cs=0 the same stimulus changes nothing.
REQ-034 Assert rst_n=0 asynchronously mid-burst -> empty=1, full=0 and data_out=0 immediately; after release, one write of 5 and one read return 5.
